// File: rtl/elev_call_dispatcher.sv
// elev_call_dispatcher: round-robin intake of floor calls into a pending
// bitmap, SCAN-ordered target sequencing toward a single elevator car.
// Optional macro DISPATCH_TIMEOUT_EN adds an arrival watchdog that drives fault.
module elev_call_dispatcher #(
   parameter int FLOORS   = 8,
   parameter int FW       = 3,
   parameter int PANELS   = 4,
   parameter int DIR_INIT = 1,
   parameter int TIMEOUT  = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PANELS-1:0]    req_valid,
   input  logic [PANELS*FW-1:0] req_floor,
   output logic [PANELS-1:0]    req_ready,
   input  logic [FW-1:0]        car_floor,
   output logic                 tgt_valid,
   output logic [FW-1:0]        tgt_floor,
   input  logic                 tgt_ack,
   input  logic                 arrive,
   output logic [FLOORS-1:0]    pending,
   output logic                 dir,
   output logic                 busy,
   output logic                 err,
   output logic                 fault
);
   localparam int RW = (PANELS > 1) ? $clog2(PANELS) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t state, state_nx;

   logic [RW-1:0]     rr, gnt_idx;
   logic              xfer, bad_floor, timeout_hit;
   logic [FW-1:0]     xfer_floor;
   logic [FLOORS-1:0] set_vec, clr_vec;
   logic              at_car, up_hit, dn_hit, fwd_hit, bwd_hit;
   logic [FW-1:0]     up_f, dn_f, fwd_f, bwd_f;

   // Round-robin grant: first valid panel at or after rr, wrapping
   always_comb begin : gnt_blk
      int p;
      req_ready = '0;
      gnt_idx   = '0;
      for (int k = 0; k < PANELS; k++) begin
         p = int'(rr) + k;
         if (p >= PANELS) p = p - PANELS;
         if (req_valid[p] && req_ready == '0) begin
            req_ready[p] = 1'b1;
            gnt_idx      = RW'(p);
         end
      end
   end

   assign xfer       = |req_ready;
   assign xfer_floor = req_floor[gnt_idx*FW +: FW];
   assign bad_floor  = xfer && (int'(xfer_floor) >= FLOORS);

   // Nearest pending floor above and below the car, plus a hit at the car itself
   always_comb begin
      at_car = 1'b0;
      up_hit = 1'b0;
      dn_hit = 1'b0;
      up_f   = '0;
      dn_f   = '0;
      for (int i = 0; i < FLOORS; i++) begin
         if (pending[i] && i == int'(car_floor)) at_car = 1'b1;
         if (pending[i] && i > int'(car_floor) && !up_hit) begin
            up_hit = 1'b1;
            up_f   = FW'(i);
         end
         if (pending[i] && i < int'(car_floor)) begin
            dn_hit = 1'b1;
            dn_f   = FW'(i);
         end
      end
      fwd_hit = dir ? up_hit : dn_hit;
      fwd_f   = dir ? up_f   : dn_f;
      bwd_hit = dir ? dn_hit : up_hit;
      bwd_f   = dir ? dn_f   : up_f;
   end

   // Bitmap set from intake, clear from service; clear wins on a collision
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int i = 0; i < FLOORS; i++) begin
         if (xfer && !bad_floor && int'(xfer_floor) == i) set_vec[i] = 1'b1;
         if (state == IDLE && at_car && int'(car_floor) == i) clr_vec[i] = 1'b1;
         if (state == WAIT && arrive && int'(tgt_floor) == i) clr_vec[i] = 1'b1;
      end
   end

`ifdef DISPATCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt;

   assign timeout_hit = (state == WAIT) && !arrive && (wait_cnt == CW'(TIMEOUT - 1));

   // Watchdog: zero outside WAIT so it starts fresh on every entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         fault    <= 1'b0;
      end else begin
         wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         if (timeout_hit) fault <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign fault       = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!at_car && (fwd_hit || bwd_hit)) state_nx = ISSUE;
         ISSUE:   if (tgt_ack) state_nx = WAIT;
         WAIT:    if (arrive || timeout_hit) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs decoded from the registered state
   always_comb begin
      tgt_valid = (state == ISSUE);
      busy      = (state != IDLE);
   end

   // Datapath: bitmap, RR pointer, target/direction selection, sticky err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending   <= '0;
         rr        <= '0;
         dir       <= 1'(DIR_INIT);
         tgt_floor <= '0;
         err       <= 1'b0;
      end else begin
         pending <= (pending | set_vec) & ~clr_vec;
         if (xfer) rr <= (int'(gnt_idx) == PANELS - 1) ? '0 : gnt_idx + 1'b1;
         if (bad_floor) err <= 1'b1;
         if (state == IDLE && !at_car) begin
            if (fwd_hit) begin
               tgt_floor <= fwd_f;
            end else if (bwd_hit) begin
               dir       <= ~dir;
               tgt_floor <= bwd_f;
            end
         end
      end
   end
endmodule

// File: tb/tb_elev_call_dispatcher.sv
// Scoreboard bench for elev_call_dispatcher: expected target floors are
// queued when calls are driven and compared as offers appear.
module tb_elev_call_dispatcher;
   localparam int FLOORS  = 7;
   localparam int FW      = 3;
   localparam int PANELS  = 4;
   localparam int TIMEOUT = 10;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [PANELS-1:0]    req_valid = '0;
   logic [PANELS*FW-1:0] req_floor = '0;
   logic [PANELS-1:0]    req_ready;
   logic [FW-1:0]        car_floor = '0;
   logic                 tgt_valid;
   logic [FW-1:0]        tgt_floor;
   logic                 tgt_ack = 1'b0;
   logic                 arrive = 1'b0;
   logic [FLOORS-1:0]    pending;
   logic                 dir, busy, err, fault;

   int total = 0;
   int bad   = 0;
   logic [FW-1:0] exp_q[$];

   elev_call_dispatcher #(.FLOORS(FLOORS), .FW(FW), .PANELS(PANELS), .DIR_INIT(1),
                          .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
      .req_ready(req_ready), .car_floor(car_floor), .tgt_valid(tgt_valid),
      .tgt_floor(tgt_floor), .tgt_ack(tgt_ack), .arrive(arrive), .pending(pending),
      .dir(dir), .busy(busy), .err(err), .fault(fault));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Single-panel call; returns just after the negedge where the bit is visible
   task automatic req1(input int p, input logic [FW-1:0] f);
      req_valid          = '0;
      req_valid[p]       = 1'b1;
      req_floor[p*FW+:FW] = f;
      #1 chk("grant", req_ready, 32'(1 << p));
      @(negedge clk);
      req_valid = '0;
   endtask

   // Wait (bounded) for an offer, compare against the scoreboard, then ack it
   task automatic take_offer(output logic [FW-1:0] f);
      logic [FW-1:0] e;
      f = '0;
      for (int n = 0; n < 50 && !tgt_valid; n++) @(negedge clk);
      if (!tgt_valid) begin
         chk("offer_wait", 0, 1);
         return;
      end
      if (exp_q.size() == 0) begin
         chk("sb_empty", 0, 1);
         e = tgt_floor;
      end else begin
         e = exp_q.pop_front();
         chk("offer", tgt_floor, e);
      end
      f = e;
      tgt_ack = 1'b1;
      @(negedge clk);
      tgt_ack = 1'b0;
      chk("ack_drop", tgt_valid, 0);
      chk("wait_busy", busy, 1);
   endtask

   task automatic arrive_at(input logic [FW-1:0] f);
      car_floor = f;
      arrive    = 1'b1;
      @(negedge clk);
      arrive = 1'b0;
      chk("served", pending[f], 0);
      chk("idle_busy", busy, 0);
   endtask

   task automatic serve();
      logic [FW-1:0] f;
      take_offer(f);
      if (tgt_ack == 1'b0 && busy) arrive_at(f);
   endtask

   initial begin
      logic [FW-1:0] f;
      // reset state
      @(negedge clk);
      chk("rst_pending", pending, 0);
      chk("rst_tgt_valid", tgt_valid, 0);
      chk("rst_dir", dir, 1);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_fault", fault, 0);
      chk("rst_ready", req_ready, 0);
      rst = 1'b0;
      @(negedge clk);

      // round-robin: all four panels hold floors 1..4
      for (int p = 0; p < PANELS; p++) req_floor[p*FW+:FW] = FW'(p + 1);
      req_valid = '1;
      for (int k = 0; k < PANELS; k++) begin
         #1 chk("rr_grant", req_ready, 32'(1 << k));
         @(negedge clk);
      end
      req_valid = '0;
      chk("rr_pending", pending, 7'b001_1110);
      for (int k = 1; k <= 4; k++) exp_q.push_back(FW'(k));
      repeat (4) serve();

      // SCAN: car at 2 going up, calls {3,5,0}
      car_floor = 2;
      req_floor[0*FW+:FW] = 3;
      req_floor[1*FW+:FW] = 5;
      req_floor[2*FW+:FW] = 0;
      req_valid = 4'b0111;
      for (int k = 0; k < 3; k++) begin
         #1 chk("scan_grant", req_ready, 32'(1 << k));
         @(negedge clk);
      end
      req_valid = '0;
      chk("scan_pending", pending, 7'b010_1001);
      exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(0);
      serve();
      serve();
      chk("scan_dir_up", dir, 1);
      serve();
      chk("scan_dir_down", dir, 0);

      // async reset while in WAIT
      car_floor = 5;
      req1(3, 2);
      exp_q.push_back(2);
      take_offer(f);
      chk("pre_rst_dir", dir, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_pending", pending, 0);
      chk("arst_tgt_valid", tgt_valid, 0);
      chk("arst_dir", dir, 1);
      chk("arst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // call at the current floor is absorbed without an offer
      car_floor = 4;
      req1(0, 4);
      chk("cur_set", pending[4], 1);
      chk("cur_no_offer0", tgt_valid, 0);
      @(negedge clk);
      chk("cur_clr", pending, 0);
      chk("cur_no_offer1", tgt_valid, 0);
      @(negedge clk);
      chk("cur_no_offer2", tgt_valid, 0);
      chk("cur_idle", busy, 0);

      // collision: call for 6 on the same edge the car arrives at 6
      req1(2, 6);
      exp_q.push_back(6);
      take_offer(f);
      car_floor = 6;
      arrive    = 1'b1;
      req_valid = 4'b0010;
      req_floor[1*FW+:FW] = 6;
      #1 chk("coll_ready", req_ready, 4'b0010);
      @(negedge clk);
      arrive    = 1'b0;
      req_valid = '0;
      chk("coll_pending", pending, 0);
      chk("coll_err", err, 0);
      chk("coll_busy", busy, 0);
      @(negedge clk);
      chk("coll_no_offer", tgt_valid, 0);

      // out-of-range floor
      req1(0, 7);
      chk("bad_err", err, 1);
      chk("bad_pending", pending, 0);
      @(negedge clk);
      chk("bad_err_hold", err, 1);

      // withheld arrival
      req1(1, 2);
      exp_q.push_back(2);
      take_offer(f);
`ifdef DISPATCH_TIMEOUT_EN
      repeat (TIMEOUT - 1) @(negedge clk);
      chk("to_fault_early", fault, 0);
      @(negedge clk);
      chk("to_fault", fault, 1);
      exp_q.push_back(2);
      serve();
      chk("to_fault_hold", fault, 1);
`else
      repeat (TIMEOUT + 5) @(negedge clk);
      chk("nto_fault", fault, 0);
      chk("nto_busy", busy, 1);
      chk("nto_tgt_valid", tgt_valid, 0);
      arrive_at(2);
`endif
      chk("sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
